// File: rtl/sync_sp_ram_req_adapter.sv
// rtl/sync_sp_ram_req_adapter.sv - valid/ready request front end for a synchronous single-port RAM
//
// Purpose:
//   Turns a valid/ready request stream into single-cycle RAM operations.
//   It also tracks the fixed RAM read latency.
//   Read data is returned on a valid/ready response stream.
//   A credit counter (Occ) covers the latency pipe plus the response buffer.
//   Because of that, downstream backpressure can never drop a RAM output beat.
//
// Optional feature (macro SYNC_SP_RAM_REQ_ADAPTER_WR_ACK_EN):
//   defined   - writes take a credit and return a zero-data ack beat, ordered with reads
//   undefined - writes produce no response and are always ready outside reset
//
// Ports:
//   Clk_CI, Rst_RI          clock, asynchronous active-high reset
//   ReqValid_SI/ReqReady_SO request handshake
//   ReqWrEn_SI              1 = write, 0 = read
//   ReqAddr_DI              request address
//   ReqWrData_DI            request write data
//   RespValid_SO            response valid
//   RespReady_SI            response ready
//   RespRdData_DO           response data
//   RamCSel_SO              RAM chip select
//   RamWrEn_SO              RAM write enable
//   RamAddr_DO              RAM address
//   RamWrData_DO            RAM write data
//   RamRdData_DI            RAM read data

module sync_sp_ram_req_adapter #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int RAM_LATENCY = 1,
   parameter int RESP_DEPTH  = 2
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RI,
   input  logic                  ReqValid_SI,
   output logic                  ReqReady_SO,
   input  logic                  ReqWrEn_SI,
   input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
   input  logic [DATA_WIDTH-1:0] ReqWrData_DI,
   output logic                  RespValid_SO,
   input  logic                  RespReady_SI,
   output logic [DATA_WIDTH-1:0] RespRdData_DO,
   output logic                  RamCSel_SO,
   output logic                  RamWrEn_SO,
   output logic [ADDR_WIDTH-1:0] RamAddr_DO,
   output logic [DATA_WIDTH-1:0] RamWrData_DO,
   input  logic [DATA_WIDTH-1:0] RamRdData_DI
);

   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RESP_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESP_DEPTH - 1);

   if (RAM_LATENCY != 1 && RAM_LATENCY != 2) begin : g_bad_latency
      $error("sync_sp_ram_req_adapter: RAM_LATENCY must be 1 or 2");
   end
   if (RESP_DEPTH < 1) begin : g_bad_depth
      $error("sync_sp_ram_req_adapter: RESP_DEPTH must be >= 1");
   end

   logic [CNT_W-1:0]       occ_q;
   logic [RAM_LATENCY-1:0] pipe_vld_q;
   logic [RAM_LATENCY-1:0] pipe_ack_q;
   logic [DATA_WIDTH-1:0]  buf_q [RESP_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       cnt_q;

   logic                   takes_credit, credit_ok, accept, consume;
   logic                   arrive, buf_empty, push, pop_buf, handover;
   logic [DATA_WIDTH-1:0]  arrive_data;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

`ifdef SYNC_SP_RAM_REQ_ADAPTER_WR_ACK_EN
   assign takes_credit = 1'b1;
`else
   assign takes_credit = ~ReqWrEn_SI;
`endif

   // Ready depends only on registered Occ and the request type.
   // It never depends on RespReady_SI.
   assign credit_ok   = (occ_q < DEPTH_C);
   assign ReqReady_SO = ~Rst_RI & (~takes_credit | credit_ok);
   assign accept      = ReqValid_SI & ReqReady_SO;
   assign consume     = accept & takes_credit;

   assign RamCSel_SO   = accept;
   assign RamWrEn_SO   = ReqWrEn_SI;
   assign RamAddr_DO   = ReqAddr_DI;
   assign RamWrData_DO = ReqWrData_DI;

   // The pipe tail marks the cycle in which RamRdData_DI belongs to us.
   assign arrive      = pipe_vld_q[RAM_LATENCY-1];
   assign arrive_data = pipe_ack_q[RAM_LATENCY-1] ? '0 : RamRdData_DI;
   assign buf_empty   = (cnt_q == '0);

   // With an empty buffer the arriving beat falls through combinationally.
   // Otherwise the buffer head is presented and the arriving beat queues behind it.
   assign RespValid_SO  = arrive | ~buf_empty;
   assign RespRdData_DO = buf_empty ? arrive_data : buf_q[rd_ptr_q];
   assign handover      = RespValid_SO & RespReady_SI;
   assign pop_buf       = ~buf_empty & RespReady_SI;
   assign push          = arrive & ~(buf_empty & RespReady_SI);

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         occ_q      <= '0;
         pipe_vld_q <= '0;
         pipe_ack_q <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         // Shift in at bit 0; the sized cast drops the bit shifted past the tail.
         pipe_vld_q <= RAM_LATENCY'({pipe_vld_q, consume});
         pipe_ack_q <= RAM_LATENCY'({pipe_ack_q, consume & ReqWrEn_SI});

         if (consume && !handover) begin
            occ_q <= occ_q + CNT_W'(1);
         end else if (!consume && handover) begin
            occ_q <= occ_q - CNT_W'(1);
         end

         if (push) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
         end
         if (pop_buf) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         if (push && !pop_buf) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else if (!push && pop_buf) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   // Data storage needs no reset; validity is carried by cnt_q.
   always_ff @(posedge Clk_CI) begin
      if (push) begin
         buf_q[wr_ptr_q] <= arrive_data;
      end
   end

endmodule

// File: tb/tb_sync_sp_ram_req_adapter.sv
// tb/tb_sync_sp_ram_req_adapter.sv - self-checking bench for sync_sp_ram_req_adapter
//
// Instance 0: RAM_LATENCY=1, RESP_DEPTH=2.  Instance 1: RAM_LATENCY=2, RESP_DEPTH=3.
// Each instance drives its own behavioural RAM model.
// The macro SYNC_SP_RAM_REQ_ADAPTER_WR_ACK_EN selects the expected write-ack behaviour.

module tb_sync_sp_ram_req_adapter;
   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic          req_valid [2];
   logic          req_ready [2];
   logic          req_wr    [2];
   logic [AW-1:0] req_addr  [2];
   logic [DW-1:0] req_wdata [2];
   logic          resp_valid[2];
   logic          resp_ready[2];
   logic [DW-1:0] resp_data [2];
   logic          ram_csel  [2];
   logic          ram_wr    [2];
   logic [AW-1:0] ram_addr  [2];
   logic [DW-1:0] ram_wdata [2];
   logic [DW-1:0] ram_rdata [2];

   sync_sp_ram_req_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(1), .RESP_DEPTH(2)) u_dut0 (
      .Clk_CI(clk), .Rst_RI(rst),
      .ReqValid_SI(req_valid[0]), .ReqReady_SO(req_ready[0]), .ReqWrEn_SI(req_wr[0]),
      .ReqAddr_DI(req_addr[0]), .ReqWrData_DI(req_wdata[0]),
      .RespValid_SO(resp_valid[0]), .RespReady_SI(resp_ready[0]), .RespRdData_DO(resp_data[0]),
      .RamCSel_SO(ram_csel[0]), .RamWrEn_SO(ram_wr[0]), .RamAddr_DO(ram_addr[0]),
      .RamWrData_DO(ram_wdata[0]), .RamRdData_DI(ram_rdata[0]));

   sync_sp_ram_req_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(2), .RESP_DEPTH(3)) u_dut1 (
      .Clk_CI(clk), .Rst_RI(rst),
      .ReqValid_SI(req_valid[1]), .ReqReady_SO(req_ready[1]), .ReqWrEn_SI(req_wr[1]),
      .ReqAddr_DI(req_addr[1]), .ReqWrData_DI(req_wdata[1]),
      .RespValid_SO(resp_valid[1]), .RespReady_SI(resp_ready[1]), .RespRdData_DO(resp_data[1]),
      .RamCSel_SO(ram_csel[1]), .RamWrEn_SO(ram_wr[1]), .RamAddr_DO(ram_addr[1]),
      .RamWrData_DO(ram_wdata[1]), .RamRdData_DI(ram_rdata[1]));

   function automatic logic [DW-1:0] init_val(input int d, input int i);
      return (DW'(d + 1) << 28) ^ (DW'(i) * 32'h0001_0003);
   endfunction

   // Behavioural RAMs: contents start at init_val, read data registered 1 or 2 times.
   for (genvar g = 0; g < 2; g++) begin : g_ram
      localparam int LAT = (g == 0) ? 1 : 2;
      logic [DW-1:0] mem [1024];
      logic [DW-1:0] q1, q2;
      bit            written [1024];
      always @(posedge clk) begin
         if (ram_csel[g]) begin
            if (ram_wr[g]) begin
               mem[ram_addr[g]]     = ram_wdata[g];
               written[ram_addr[g]] = 1'b1;
            end else begin
               q1 <= written[ram_addr[g]] ? mem[ram_addr[g]] : init_val(g, int'(ram_addr[g]));
            end
         end
         q2 <= q1;
      end
      assign ram_rdata[g] = (LAT == 1) ? q1 : q2;
   end

   // Independent shadow of what each RAM should hold, kept by the scoreboard.
   logic [DW-1:0] shadow  [2][1024];
   bit            sh_wr   [2][1024];

   function automatic logic [DW-1:0] exp_mem(input int d, input int i);
      return sh_wr[d][i] ? shadow[d][i] : init_val(d, i);
   endfunction

   logic [DW-1:0] sbq0 [$];
   logic [DW-1:0] sbq1 [$];

   // Scoreboard: pop/compare on handover, push expected beat on accept.
   always @(negedge clk) begin
      if (rst) begin
         sbq0.delete();
         sbq1.delete();
      end else begin
         for (int d = 0; d < 2; d++) begin
            logic [DW-1:0] e;
            int            sz;
            if (resp_valid[d] && resp_ready[d]) begin
               sz = (d == 0) ? sbq0.size() : sbq1.size();
               checks++;
               if (sz == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected dut%0d got %h required no beat", d, resp_data[d]);
               end else begin
                  if (d == 0) e = sbq0.pop_front();
                  else        e = sbq1.pop_front();
                  if (resp_data[d] !== e) begin
                     errors++;
                     $display("FAIL sb_data dut%0d got %h required %h", d, resp_data[d], e);
                  end
               end
            end
            if (req_valid[d] && req_ready[d]) begin
               if (req_wr[d]) begin
                  shadow[d][req_addr[d]] = req_wdata[d];
                  sh_wr[d][req_addr[d]]  = 1'b1;
`ifdef SYNC_SP_RAM_REQ_ADAPTER_WR_ACK_EN
                  if (d == 0) sbq0.push_back('0);
                  else        sbq1.push_back('0);
`endif
               end else begin
                  if (d == 0) sbq0.push_back(exp_mem(d, int'(req_addr[d])));
                  else        sbq1.push_back(exp_mem(d, int'(req_addr[d])));
               end
            end
         end
      end
   end

   task automatic send(input int d, input logic wr, input int addr, input logic [DW-1:0] data,
                       output int waits);
      waits = 0;
      req_valid[d] = 1'b1;
      req_wr[d]    = wr;
      req_addr[d]  = AW'(addr);
      req_wdata[d] = data;
      @(negedge clk);
      while (!req_ready[d] && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      checks++;
      if (!req_ready[d]) begin
         errors++;
         $display("FAIL send_timeout dut%0d addr %0d ready %b required 1", d, addr, req_ready[d]);
      end
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
   endtask

   task automatic wait_empty(input int d);
      for (int i = 0; i < 40; i++) begin
         if (((d == 0) ? sbq0.size() : sbq1.size()) == 0) break;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b1; req_wr[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
         resp_ready[d] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 || ram_csel[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d got rdy=%b vld=%b csel=%b required 0 0 0",
                     d, req_ready[d], resp_valid[d], ram_csel[d]);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready dut%0d got %b required 1", d, req_ready[d]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_read();
      int w;
      resp_ready[0] = 1'b1;
      req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = AW'(5); req_wdata[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if (ram_csel[0] !== 1'b1 || ram_wr[0] !== 1'b1 || ram_addr[0] !== AW'(5) ||
          ram_wdata[0] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL ram_port_write got csel=%b wr=%b addr=%0d wd=%h required 1 1 5 deadbeef",
                  ram_csel[0], ram_wr[0], ram_addr[0], ram_wdata[0]);
      end
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      send(0, 1'b0, 5, '0, w);
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL read_after_write got vld=%b data=%h required 1 deadbeef",
                  resp_valid[0], resp_data[0]);
      end
      wait_empty(0);
   endtask

   task automatic test_back_to_back();
      resp_ready[1] = 1'b1;
      fork
         begin
            int w;
            for (int k = 0; k < 8; k++) begin
               send(1, 1'b0, k, '0, w);
               checks++;
               if (w != 0) begin
                  errors++;
                  $display("FAIL b2b_ready_stall read %0d waited %0d required 0", k, w);
               end
            end
         end
         begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (resp_valid[1] !== 1'b0) begin
               errors++;
               $display("FAIL b2b_early_resp got %b required 0", resp_valid[1]);
            end
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               checks++;
               if (resp_valid[1] !== 1'b1 || resp_data[1] !== exp_mem(1, k)) begin
                  errors++;
                  $display("FAIL b2b_resp beat %0d got vld=%b data=%h required 1 %h",
                           k, resp_valid[1], resp_data[1], exp_mem(1, k));
               end
            end
            @(negedge clk);
            checks++;
            if (resp_valid[1] !== 1'b0) begin
               errors++;
               $display("FAIL b2b_extra_resp got %b required 0", resp_valid[1]);
            end
         end
      join
      wait_empty(1);
   endtask

   task automatic test_backpressure();
      int w;
      resp_ready[0] = 1'b0;
      send(0, 1'b0, 10, '0, w);
      send(0, 1'b0, 11, '0, w);
      fork
         begin
            int w2;
            send(0, 1'b0, 12, '0, w2);
            send(0, 1'b0, 13, '0, w2);
         end
         begin
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               checks++;
               if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b1 || resp_data[0] !== exp_mem(0, 10)) begin
                  errors++;
                  $display("FAIL bp_hold cycle %0d got rdy=%b vld=%b data=%h required 0 1 %h",
                           k, req_ready[0], resp_valid[0], resp_data[0], exp_mem(0, 10));
               end
            end
            @(posedge clk);
            #1;
            resp_ready[0] = 1'b1;
         end
      join
      wait_empty(0);
      checks++;
      if (sbq0.size() != 0) begin
         errors++;
         $display("FAIL bp_drain pending %0d required 0", sbq0.size());
      end
   endtask

   task automatic test_credit_toggle();
      int  w;
      bit  acc;
      logic exp_rdy;
      resp_ready[0] = 1'b0;
      send(0, 1'b0, 20, '0, w);
      send(0, 1'b0, 21, '0, w);
      req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = AW'(30);
      for (int i = 0; i < 8; i++) begin
         resp_ready[0] = i[0];
         @(negedge clk);
         exp_rdy = (i % 2 == 0) && (i > 0);
         checks++;
         if (req_ready[0] !== exp_rdy || resp_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL credit_toggle cycle %0d got rdy=%b vld=%b required %b 1",
                     i, req_ready[0], resp_valid[0], exp_rdy);
         end
         acc = req_ready[0];
         @(posedge clk);
         #1;
         if (acc) req_addr[0] = req_addr[0] + AW'(1);
      end
      req_valid[0]  = 1'b0;
      resp_ready[0] = 1'b1;
      wait_empty(0);
      checks++;
      if (sbq0.size() != 0) begin
         errors++;
         $display("FAIL credit_drain pending %0d required 0", sbq0.size());
      end
   endtask

   task automatic test_reset_flush();
      int w;
      resp_ready[1] = 1'b0;
      send(1, 1'b0, 40, '0, w);
      send(1, 1'b0, 41, '0, w);
      send(1, 1'b0, 42, '0, w);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
         errors++;
         $display("FAIL flush_in_reset got vld=%b rdy=%b required 0 0", resp_valid[1], req_ready[1]);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      resp_ready[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL flush_stale cycle %0d got vld=%b rdy=%b required 0 1",
                     k, resp_valid[1], req_ready[1]);
         end
      end
      @(posedge clk);
      #1;
      send(1, 1'b0, 43, '0, w);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (resp_valid[1] !== 1'b1 || resp_data[1] !== exp_mem(1, 43)) begin
         errors++;
         $display("FAIL flush_next_read got vld=%b data=%h required 1 %h",
                  resp_valid[1], resp_data[1], exp_mem(1, 43));
      end
      wait_empty(1);
   endtask

   task automatic test_wr_ack();
      int w;
      resp_ready[0] = 1'b1;
      send(0, 1'b1, 3, 32'h1234_5678, w);
      @(negedge clk);
      checks++;
`ifdef SYNC_SP_RAM_REQ_ADAPTER_WR_ACK_EN
      if (resp_valid[0] !== 1'b1 || resp_data[0] !== '0) begin
         errors++;
         $display("FAIL wr_ack_beat got vld=%b data=%h required 1 0", resp_valid[0], resp_data[0]);
      end
`else
      if (resp_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL wr_no_ack got vld=%b required 0", resp_valid[0]);
      end
`endif
      @(posedge clk);
      #1;
      send(0, 1'b0, 3, '0, w);
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'h1234_5678) begin
         errors++;
         $display("FAIL wr_ack_read got vld=%b data=%h required 1 12345678", resp_valid[0], resp_data[0]);
      end
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL wr_ack_extra got vld=%b required 0", resp_valid[0]);
      end
      wait_empty(0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_credit_toggle();
      test_reset_flush();
      test_wr_ack();
      checks++;
      if (sbq0.size() != 0 || sbq1.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d/%0d required 0/0", sbq0.size(), sbq1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
